// File: rtl/dma_status_tracker_pkg.sv
// -----------------------------------------------------------------------------
// dma_status_tracker_pkg
// Shared definitions for the DMA status tracker slice.
//   state_t         : job lifecycle states (IDLE / WED_FETCH / RUN / DRAIN)
//   JOB_CNT_W       : width of the completed-job counter
//   WR_SIZE_W       : width of the per-job written-byte accumulator
//   MAX_RESP_BYTES  : largest byte count a single write response can report
//   sat_add_size()  : saturating accumulate for the written-byte total
// -----------------------------------------------------------------------------
package dma_status_tracker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WED_FETCH = 2'd1,
      ST_RUN       = 2'd2,
      ST_DRAIN     = 2'd3
   } state_t;

   localparam int             JOB_CNT_W      = 16;
   localparam int             WR_SIZE_W      = 32;
   localparam logic [7:0]     MAX_RESP_BYTES = 8'd128;

   // Adds one response's byte count to the running total, sticking at
   // all-ones instead of wrapping so a huge job never reads back as small.
   function automatic logic [WR_SIZE_W-1:0] sat_add_size(
      input logic [WR_SIZE_W-1:0] acc,
      input logic [7:0]           bytes
   );
      logic [WR_SIZE_W:0] sum;
      sum = {1'b0, acc} + {{(WR_SIZE_W-7){1'b0}}, bytes};
      return sum[WR_SIZE_W] ? {WR_SIZE_W{1'b1}} : sum[WR_SIZE_W-1:0];
   endfunction

endpackage

// File: rtl/dma_status_tracker_outst_counter.sv
// -----------------------------------------------------------------------------
// outst_counter
// Clamping up/down counter of outstanding PSL commands in one direction.
// Ports:
//   ha_pclock  in   clock
//   reset      in   synchronous active-high reset
//   inc        in   command issued this cycle
//   dec        in   response received this cycle
//   count      out  registered outstanding count
//   nonzero    out  count != 0
//   underflow  out  this cycle's response arrives with nothing outstanding
//   overflow   out  this cycle's issue arrives with the counter already full
// -----------------------------------------------------------------------------
module outst_counter
   import dma_status_tracker_pkg::*;
#(
   parameter int OUTST_W = 8
) (
   input  logic               ha_pclock,
   input  logic               reset,
   input  logic               inc,
   input  logic               dec,
   output logic [OUTST_W-1:0] count,
   output logic               nonzero,
   output logic               underflow,
   output logic               overflow
);

   localparam logic [OUTST_W-1:0] CNT_MAX = {OUTST_W{1'b1}};

   // A simultaneous issue and response cancel out, so the clamp flags only
   // fire for a lone event that would push the count past either end.
   assign underflow = dec && !inc && (count == '0);
   assign overflow  = inc && !dec && (count == CNT_MAX);
   assign nonzero   = (count != '0);

   // Count register: move by one unless the move would wrap, in which case
   // the count simply holds at its end stop.
   always_ff @(posedge ha_pclock) begin
      if (reset) begin
         count <= '0;
      end else if (inc && !dec && !overflow) begin
         count <= count + 1'b1;
      end else if (dec && !inc && !underflow) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/dma_status_tracker.sv
// -----------------------------------------------------------------------------
// dma_status_tracker
// Follows the single dedicated-process job through IDLE -> WED_FETCH -> RUN ->
// DRAIN -> IDLE and summarises its DMA traffic for the MMIO status word.
// Optional feature macro: STATUS_ERR_CHECK_EN (enables sticky status_err).
// Ports:
//   ha_pclock, reset     clock, synchronous active-high reset
//   job_start            pulse: job started
//   job_done_req         pulse: job end / abort requested
//   wed_val              pulse: WED data returned
//   rd_cmd_issue/rd_resp read command issued / read response received
//   wr_cmd_issue/wr_resp write command issued / write response received
//   wr_resp_bytes        bytes completed by the current write response
//   job_working          job active (state not IDLE)
//   wed_data_val         WED received for the current job
//   on_reading           reads outstanding
//   on_writting          writes outstanding
//   job_counter          completed jobs since reset (wraps)
//   write_size           bytes written in current / last job (saturates)
//   job_done             one-cycle pulse when the job has fully drained
//   status_err           sticky protocol error (0 unless macro defined)
// -----------------------------------------------------------------------------
module dma_status_tracker
   import dma_status_tracker_pkg::*;
#(
   parameter int OUTST_W = 8
) (
   input  logic                 ha_pclock,
   input  logic                 reset,
   input  logic                 job_start,
   input  logic                 job_done_req,
   input  logic                 wed_val,
   input  logic                 rd_cmd_issue,
   input  logic                 rd_resp,
   input  logic                 wr_cmd_issue,
   input  logic                 wr_resp,
   input  logic [0:7]           wr_resp_bytes,
   output logic                 job_working,
   output logic                 wed_data_val,
   output logic                 on_reading,
   output logic                 on_writting,
   output logic [0:JOB_CNT_W-1] job_counter,
   output logic [0:WR_SIZE_W-1] write_size,
   output logic                 job_done,
   output logic                 status_err
);

   localparam logic [OUTST_W-1:0] OUTST_ONE = OUTST_W'(1);

   state_t             state, state_next;
   logic               job_accept, wed_accept, drain_exit;
   logic [OUTST_W-1:0] rd_count, wr_count;
   logic               rd_nonzero, wr_nonzero;
   logic               rd_under, rd_over, wr_under, wr_over;
   logic               rd_next_zero, wr_next_zero;
   logic [7:0]         resp_bytes;

   outst_counter #(.OUTST_W(OUTST_W)) u_rd_cnt (
      .ha_pclock (ha_pclock),
      .reset     (reset),
      .inc       (rd_cmd_issue),
      .dec       (rd_resp),
      .count     (rd_count),
      .nonzero   (rd_nonzero),
      .underflow (rd_under),
      .overflow  (rd_over)
   );

   outst_counter #(.OUTST_W(OUTST_W)) u_wr_cnt (
      .ha_pclock (ha_pclock),
      .reset     (reset),
      .inc       (wr_cmd_issue),
      .dec       (wr_resp),
      .count     (wr_count),
      .nonzero   (wr_nonzero),
      .underflow (wr_under),
      .overflow  (wr_over)
   );

   // The drain check looks at where each counter lands after this cycle's
   // events, so the last response and job_done are only one edge apart.
   assign rd_next_zero = (!rd_nonzero && !(rd_cmd_issue && !rd_resp)) ||
                         ((rd_count == OUTST_ONE) && rd_resp && !rd_cmd_issue);
   assign wr_next_zero = (!wr_nonzero && !(wr_cmd_issue && !wr_resp)) ||
                         ((wr_count == OUTST_ONE) && wr_resp && !wr_cmd_issue);

   // Out-of-range byte counts are clipped so one bad response cannot
   // inflate the total beyond a legal transfer.
   assign resp_bytes = (wr_resp_bytes > MAX_RESP_BYTES) ? MAX_RESP_BYTES : wr_resp_bytes;

   // Next-state logic for the job lifecycle. An end request while still
   // waiting on the WED is an abort and takes priority over the WED arriving.
   always_comb begin
      state_next = state;
      job_accept = 1'b0;
      wed_accept = 1'b0;
      drain_exit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (job_start) begin
               state_next = ST_WED_FETCH;
               job_accept = 1'b1;
            end
         end
         ST_WED_FETCH: begin
            if (job_done_req) begin
               state_next = ST_DRAIN;
            end else if (wed_val) begin
               state_next = ST_RUN;
               wed_accept = 1'b1;
            end
         end
         ST_RUN: begin
            if (job_done_req) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (rd_next_zero && wr_next_zero) begin
               state_next = ST_IDLE;
               drain_exit = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge ha_pclock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Per-job status flags and the completion pulse / job tally. A reset
   // mid-job clears everything, so an abandoned job never reaches the tally.
   always_ff @(posedge ha_pclock) begin
      if (reset) begin
         wed_data_val <= 1'b0;
         job_done     <= 1'b0;
         job_counter  <= '0;
      end else begin
         job_done <= drain_exit;
         if (drain_exit) begin
            job_counter <= job_counter + 1'b1;
         end
         if (job_accept) begin
            wed_data_val <= 1'b0;
         end else if (wed_accept) begin
            wed_data_val <= 1'b1;
         end
      end
   end

   // Written-byte total: restarts with each new job, accumulates every write
   // response regardless of state, and is kept after the job for readback.
   always_ff @(posedge ha_pclock) begin
      if (reset) begin
         write_size <= '0;
      end else if (job_accept) begin
         write_size <= '0;
      end else if (wr_resp) begin
         write_size <= sat_add_size(write_size, resp_bytes);
      end
   end

`ifdef STATUS_ERR_CHECK_EN
   // Sticky protocol error: any clamped counter event or any lifecycle strobe
   // arriving in a state that ignores it latches until reset.
   always_ff @(posedge ha_pclock) begin
      if (reset) begin
         status_err <= 1'b0;
      end else if (rd_under || rd_over || wr_under || wr_over ||
                   (job_start && (state != ST_IDLE)) ||
                   (wed_val && (state != ST_WED_FETCH))) begin
         status_err <= 1'b1;
      end
   end
`else
   // Error reporting compiled out; the clamp flags are intentionally dropped.
   logic unused_err_flags;
   assign unused_err_flags = rd_under ^ rd_over ^ wr_under ^ wr_over;
   assign status_err       = 1'b0;
`endif

   // Status bits straight off the state and counter registers.
   assign job_working = (state != ST_IDLE);
   assign on_reading  = rd_nonzero;
   assign on_writting = wr_nonzero;

endmodule

// File: tb/tb_dma_status_tracker.sv
// -----------------------------------------------------------------------------
// tb_dma_status_tracker
// Directed self-checking bench for dma_status_tracker. Inputs change just after
// each falling edge; outputs are sampled at the next falling edge, i.e. after
// exactly one rising edge. Follows STATUS_ERR_CHECK_EN for status_err.
// -----------------------------------------------------------------------------
module tb_dma_status_tracker;

   logic        ha_pclock = 1'b0;
   logic        reset;
   logic        job_start, job_done_req, wed_val;
   logic        rd_cmd_issue, rd_resp, wr_cmd_issue, wr_resp;
   logic [0:7]  wr_resp_bytes;
   logic        job_working, wed_data_val, on_reading, on_writting;
   logic [0:15] job_counter;
   logic [0:31] write_size;
   logic        job_done, status_err;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_jobs = 16'd0;
   logic        exp_err;

   dma_status_tracker #(.OUTST_W(8)) dut (
      .ha_pclock     (ha_pclock),
      .reset         (reset),
      .job_start     (job_start),
      .job_done_req  (job_done_req),
      .wed_val       (wed_val),
      .rd_cmd_issue  (rd_cmd_issue),
      .rd_resp       (rd_resp),
      .wr_cmd_issue  (wr_cmd_issue),
      .wr_resp       (wr_resp),
      .wr_resp_bytes (wr_resp_bytes),
      .job_working   (job_working),
      .wed_data_val  (wed_data_val),
      .on_reading    (on_reading),
      .on_writting   (on_writting),
      .job_counter   (job_counter),
      .write_size    (write_size),
      .job_done      (job_done),
      .status_err    (status_err)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 ha_pclock = ~ha_pclock;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic clear_inputs();
      job_start     = 1'b0;
      job_done_req  = 1'b0;
      wed_val       = 1'b0;
      rd_cmd_issue  = 1'b0;
      rd_resp       = 1'b0;
      wr_cmd_issue  = 1'b0;
      wr_resp       = 1'b0;
      wr_resp_bytes = 8'd0;
   endtask

   // Advance one rising edge and land on the following falling edge.
   task automatic cycle();
      @(negedge ha_pclock);
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      checks++; if (job_working !== 1'b0) begin errors++; $display("[TB] FAIL rst_working: got %0b want 0", job_working); end
      checks++; if (wed_data_val !== 1'b0) begin errors++; $display("[TB] FAIL rst_wed: got %0b want 0", wed_data_val); end
      checks++; if (on_reading !== 1'b0) begin errors++; $display("[TB] FAIL rst_reading: got %0b want 0", on_reading); end
      checks++; if (on_writting !== 1'b0) begin errors++; $display("[TB] FAIL rst_writting: got %0b want 0", on_writting); end
      checks++; if (job_counter !== 16'h0000) begin errors++; $display("[TB] FAIL rst_jobcnt: got %h want 0000", job_counter); end
      checks++; if (write_size !== 32'h0) begin errors++; $display("[TB] FAIL rst_wsize: got %h want 0", write_size); end
      checks++; if (job_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %0b want 0", job_done); end
      checks++; if (status_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %0b want 0", status_err); end
      cycle();
      checks++; if (job_working !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_hold: got %0b want 0", job_working); end
   endtask

   task automatic test_basic_job();
      job_start = 1'b1; cycle(); clear_inputs();
      checks++; if (job_working !== 1'b1) begin errors++; $display("[TB] FAIL basic_start: got %0b want 1", job_working); end
      checks++; if (wed_data_val !== 1'b0) begin errors++; $display("[TB] FAIL basic_wed_pre: got %0b want 0", wed_data_val); end
      wed_val = 1'b1; cycle(); clear_inputs();
      checks++; if (wed_data_val !== 1'b1) begin errors++; $display("[TB] FAIL basic_wed: got %0b want 1", wed_data_val); end
      for (int i = 0; i < 3; i++) begin rd_cmd_issue = 1'b1; cycle(); end
      clear_inputs();
      checks++; if (on_reading !== 1'b1) begin errors++; $display("[TB] FAIL basic_reading: got %0b want 1", on_reading); end
      for (int i = 0; i < 3; i++) begin rd_resp = 1'b1; cycle(); end
      clear_inputs();
      checks++; if (on_reading !== 1'b0) begin errors++; $display("[TB] FAIL basic_read_drained: got %0b want 0", on_reading); end
      for (int i = 0; i < 2; i++) begin wr_cmd_issue = 1'b1; cycle(); end
      clear_inputs();
      checks++; if (on_writting !== 1'b1) begin errors++; $display("[TB] FAIL basic_writting: got %0b want 1", on_writting); end
      for (int i = 0; i < 2; i++) begin wr_resp = 1'b1; wr_resp_bytes = 8'd128; cycle(); end
      clear_inputs();
      checks++; if (on_writting !== 1'b0) begin errors++; $display("[TB] FAIL basic_write_drained: got %0b want 0", on_writting); end
      checks++; if (write_size !== 32'd256) begin errors++; $display("[TB] FAIL basic_wsize: got %0d want 256", write_size); end
      job_done_req = 1'b1; cycle(); clear_inputs();
      checks++; if (job_working !== 1'b1) begin errors++; $display("[TB] FAIL basic_drain_working: got %0b want 1", job_working); end
      checks++; if (job_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_early: got %0b want 0", job_done); end
      cycle();
      exp_jobs = exp_jobs + 16'd1;
      checks++; if (job_done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done: got %0b want 1", job_done); end
      checks++; if (job_working !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: got %0b want 0", job_working); end
      checks++; if (job_counter !== exp_jobs) begin errors++; $display("[TB] FAIL basic_jobcnt: got %h want %h", job_counter, exp_jobs); end
      cycle();
      checks++; if (job_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %0b want 0", job_done); end
      checks++; if (write_size !== 32'd256) begin errors++; $display("[TB] FAIL basic_wsize_hold: got %0d want 256", write_size); end
   endtask

   task automatic test_drain_wait();
      job_start = 1'b1; cycle(); clear_inputs();
      checks++; if (write_size !== 32'd0) begin errors++; $display("[TB] FAIL drain_wsize_clr: got %0d want 0", write_size); end
      wed_val = 1'b1; cycle(); clear_inputs();
      for (int i = 0; i < 2; i++) begin wr_cmd_issue = 1'b1; cycle(); end
      clear_inputs();
      job_done_req = 1'b1; cycle(); clear_inputs();
      repeat (2) cycle();
      checks++; if (job_working !== 1'b1) begin errors++; $display("[TB] FAIL drain_hold: got %0b want 1", job_working); end
      checks++; if (on_writting !== 1'b1) begin errors++; $display("[TB] FAIL drain_writting: got %0b want 1", on_writting); end
      checks++; if (job_done !== 1'b0) begin errors++; $display("[TB] FAIL drain_no_done: got %0b want 0", job_done); end
      wr_resp = 1'b1; wr_resp_bytes = 8'd16; cycle(); clear_inputs();
      checks++; if (job_done !== 1'b0) begin errors++; $display("[TB] FAIL drain_one_left: got %0b want 0", job_done); end
      checks++; if (on_writting !== 1'b1) begin errors++; $display("[TB] FAIL drain_one_writting: got %0b want 1", on_writting); end
      wr_resp = 1'b1; wr_resp_bytes = 8'd16; cycle(); clear_inputs();
      exp_jobs = exp_jobs + 16'd1;
      checks++; if (job_done !== 1'b1) begin errors++; $display("[TB] FAIL drain_done: got %0b want 1", job_done); end
      checks++; if (job_working !== 1'b0) begin errors++; $display("[TB] FAIL drain_idle: got %0b want 0", job_working); end
      checks++; if (write_size !== 32'd32) begin errors++; $display("[TB] FAIL drain_wsize: got %0d want 32", write_size); end
      checks++; if (job_counter !== exp_jobs) begin errors++; $display("[TB] FAIL drain_jobcnt: got %h want %h", job_counter, exp_jobs); end
      cycle();
   endtask

   task automatic test_simultaneous();
      job_start = 1'b1; cycle(); clear_inputs();
      wed_val = 1'b1; cycle(); clear_inputs();
      job_start = 1'b1; cycle(); clear_inputs();
      checks++; if (wed_data_val !== 1'b1) begin errors++; $display("[TB] FAIL sim_restart_ignored: got %0b want 1", wed_data_val); end
      rd_cmd_issue = 1'b1; cycle(); clear_inputs();
      rd_cmd_issue = 1'b1; rd_resp = 1'b1; cycle(); clear_inputs();
      checks++; if (on_reading !== 1'b1) begin errors++; $display("[TB] FAIL sim_both: got %0b want 1", on_reading); end
      rd_resp = 1'b1; cycle(); clear_inputs();
      checks++; if (on_reading !== 1'b0) begin errors++; $display("[TB] FAIL sim_count_was_one: got %0b want 0", on_reading); end
      job_done_req = 1'b1; cycle(); clear_inputs();
      cycle();
      exp_jobs = exp_jobs + 16'd1;
      checks++; if (job_counter !== exp_jobs) begin errors++; $display("[TB] FAIL sim_jobcnt: got %h want %h", job_counter, exp_jobs); end
      cycle();
   endtask

   task automatic test_wrap_saturation();
      force dut.job_counter = 16'hFFFF;
      #1;
      release dut.job_counter;
      exp_jobs = 16'hFFFF;
      cycle();
      job_start = 1'b1; cycle(); clear_inputs();
      force dut.write_size = 32'hFFFFFF80;
      #1;
      release dut.write_size;
      wed_val = 1'b1; cycle(); clear_inputs();
      checks++; if (write_size !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL sat_preload: got %h want FFFFFF80", write_size); end
      wr_cmd_issue = 1'b1; cycle(); clear_inputs();
      wr_resp = 1'b1; wr_resp_bytes = 8'd128; cycle(); clear_inputs();
      checks++; if (write_size !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL sat_reach: got %h want FFFFFFFF", write_size); end
      wr_cmd_issue = 1'b1; cycle(); clear_inputs();
      wr_resp = 1'b1; wr_resp_bytes = 8'd1; cycle(); clear_inputs();
      checks++; if (write_size !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL sat_hold: got %h want FFFFFFFF", write_size); end
      job_done_req = 1'b1; cycle(); clear_inputs();
      cycle();
      exp_jobs = exp_jobs + 16'd1;
      checks++; if (job_counter !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_jobcnt: got %h want 0000", job_counter); end
      checks++; if (job_done !== 1'b1) begin errors++; $display("[TB] FAIL wrap_done: got %0b want 1", job_done); end
      cycle();
   endtask

   task automatic test_errors();
`ifdef STATUS_ERR_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      rd_resp = 1'b1; cycle(); clear_inputs();
      checks++; if (on_reading !== 1'b0) begin errors++; $display("[TB] FAIL under_clamp: got %0b want 0", on_reading); end
      checks++; if (status_err !== exp_err) begin errors++; $display("[TB] FAIL under_err: got %0b want %0b", status_err, exp_err); end
      rd_cmd_issue = 1'b1; cycle(); clear_inputs();
      checks++; if (on_reading !== 1'b1) begin errors++; $display("[TB] FAIL under_recover: got %0b want 1", on_reading); end
      rd_resp = 1'b1; cycle(); clear_inputs();
      for (int i = 0; i < 256; i++) begin rd_cmd_issue = 1'b1; cycle(); end
      clear_inputs();
      checks++; if (on_reading !== 1'b1) begin errors++; $display("[TB] FAIL over_clamp: got %0b want 1", on_reading); end
      for (int i = 0; i < 254; i++) begin rd_resp = 1'b1; cycle(); end
      clear_inputs();
      checks++; if (on_reading !== 1'b1) begin errors++; $display("[TB] FAIL over_254: got %0b want 1", on_reading); end
      rd_resp = 1'b1; cycle(); clear_inputs();
      checks++; if (on_reading !== 1'b0) begin errors++; $display("[TB] FAIL over_255: got %0b want 0", on_reading); end
      checks++; if (status_err !== exp_err) begin errors++; $display("[TB] FAIL err_sticky: got %0b want %0b", status_err, exp_err); end
   endtask

   task automatic test_reset_mid_job();
      job_start = 1'b1; cycle(); clear_inputs();
      wed_val = 1'b1; cycle(); clear_inputs();
      for (int i = 0; i < 4; i++) begin rd_cmd_issue = 1'b1; cycle(); end
      clear_inputs();
      checks++; if (on_reading !== 1'b1) begin errors++; $display("[TB] FAIL mid_reading: got %0b want 1", on_reading); end
      reset = 1'b1; cycle(); reset = 1'b0;
      checks++; if (job_working !== 1'b0) begin errors++; $display("[TB] FAIL mid_working: got %0b want 0", job_working); end
      checks++; if (wed_data_val !== 1'b0) begin errors++; $display("[TB] FAIL mid_wed: got %0b want 0", wed_data_val); end
      checks++; if (on_reading !== 1'b0) begin errors++; $display("[TB] FAIL mid_reading_clr: got %0b want 0", on_reading); end
      checks++; if (job_counter !== exp_jobs) begin errors++; $display("[TB] FAIL mid_jobcnt: got %h want %h", job_counter, exp_jobs); end
      checks++; if (write_size !== 32'h0) begin errors++; $display("[TB] FAIL mid_wsize: got %h want 0", write_size); end
      checks++; if (status_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_err: got %0b want 0", status_err); end
      cycle();
      checks++; if (job_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_done: got %0b want 0", job_done); end
   endtask

   // Scenario sequence; the wrap test leaves the expected job count at zero,
   // which is also the post-reset value checked by the mid-job reset test.
   initial begin
      clear_inputs();
      reset = 1'b1;
      $display("[TB] starting dma_status_tracker bench");
      test_reset();
      test_basic_job();
      test_drain_wait();
      test_simultaneous();
      test_wrap_saturation();
      test_errors();
      test_reset_mid_job();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dma_status_tracker.md
# dma_status_tracker

Tracks the lifecycle of the single dedicated-process job and the DMA traffic it generates. Produces the live status word fields (`job_working`, `wed_data_val`, `on_reading`, `on_writting`, `job_counter`, `write_size`) consumed by the MMIO register bank. It sits between job control / DMA engine event strobes and the MMIO status read path. All outputs are registered.

## Interface
Parameters:
- OUTST_W, 8, width of the outstanding read/write command counters; max outstanding = 2^OUTST_W − 1.

Ports:
- ha_pclock  in  1  clock.
- reset  in  1  synchronous, active-high.
- job_start  in  1  one-cycle pulse: job started (PSL start command accepted).
- job_done_req  in  1  one-cycle pulse: job end or abort requested.
- wed_val  in  1  one-cycle pulse: WED data returned.
- rd_cmd_issue  in  1  read command issued to PSL.
- rd_resp  in  1  read response received.
- wr_cmd_issue  in  1  write command issued to PSL.
- wr_resp  in  1  write response received.
- wr_resp_bytes  in  [0:7]  bytes completed by this write response, 0..128.
- job_working  out  1  job active: any state other than IDLE.
- wed_data_val  out  1  WED received for the current job.
- on_reading  out  1  read outstanding count ≠ 0.
- on_writting  out  1  write outstanding count ≠ 0.
- job_counter  out  [0:15]  number of completed jobs since reset.
- write_size  out  [0:31]  bytes written in the current or last job.
- job_done  out  1  one-cycle pulse when the job fully drains.
- status_err  out  1  sticky protocol error (see Configuration).

## Operation
- State machine with four states: IDLE, WED_FETCH, RUN, DRAIN.
  - IDLE → WED_FETCH on `job_start`. The same edge clears `write_size` and `wed_data_val`.
  - WED_FETCH → RUN on `wed_val`, which sets `wed_data_val`. `job_done_req` in WED_FETCH is an abort and goes directly to DRAIN.
  - RUN → DRAIN on `job_done_req`.
  - DRAIN → IDLE when both outstanding counters are 0. On that transition, `job_done` pulses and `job_counter` increments.
- `job_counter` wraps mod 2^16 (0xFFFF + 1 → 0x0000).
- `job_start` outside IDLE is ignored. `wed_val` outside WED_FETCH is ignored.
- Outstanding counters: one per direction.
  - Next value = count + issue − resp.
  - Simultaneous issue and resp leaves the count unchanged.
  - A resp at count 0 holds the count at 0 (underflow).
  - An issue at max holds the count at max (overflow).
- `write_size` += `wr_resp_bytes` on each `wr_resp`, in any state. It saturates at 0xFFFFFFFF and holds its value after the job ends, until the next `job_start`.

## Timing
- Every output is registered. An input event at cycle N is reflected at cycle N+1.
- `job_done` is asserted exactly one cycle, in the cycle after the DRAIN exit condition holds.
- If DRAIN is entered with both counters already 0, the exit to IDLE happens on the following cycle. `job_working` is therefore high for at least 2 cycles after `job_done_req`.
- Reset values: state IDLE; all counters 0; `job_working`, `wed_data_val`, `on_reading`, `on_writting`, `job_done` and `status_err` are 0; `job_counter` = 0; `write_size` = 0.
- Reset asserted mid-job discards all state. The abandoned job is not counted.

## Configuration
- `STATUS_ERR_CHECK_EN` defined:
  - `status_err` is set on any of: counter underflow, counter overflow, `job_start` outside IDLE, `wed_val` outside WED_FETCH.
  - `status_err` stays set until reset.
- Not defined: `status_err` is tied to 0 and the detection logic is removed. Counter clamping still applies.

## Structure
- Shared package holds:
  - the state typedef (IDLE / WED_FETCH / RUN / DRAIN);
  - `JOB_CNT_W` = 16;
  - `WR_SIZE_W` = 32;
  - `MAX_RESP_BYTES` = 128.
- One sub-module, `outst_counter`:
  - parameter OUTST_W;
  - inputs: `inc`, `dec`;
  - outputs: `count`, `nonzero`, `underflow`, `overflow`;
  - instantiated twice, once for reads and once for writes.

## Test plan
- Basic job: `job_start`, then `wed_val`, 3 `rd_cmd_issue`, 3 `rd_resp`, 2 `wr_cmd_issue`, 2 `wr_resp` of 128 bytes each, then `job_done_req`. Expect `write_size` = 256, `job_done` pulses once, `job_counter` = 1, `job_working` = 0.
- Drain wait: `job_done_req` while 2 writes are outstanding. Expect state to stay DRAIN and `on_writting` = 1. The final `wr_resp` is followed one cycle later by `job_done`.
- Simultaneous events: `rd_cmd_issue` and `rd_resp` in the same cycle at count 1. Expect count stays 1 and `on_reading` stays 1.
- Wrap and saturation:
  - Preload `job_counter` to 0xFFFF and complete a job → 0x0000.
  - `write_size` at 0xFFFFFF80 plus a 128-byte response → 0xFFFFFFFF.
- Errors (with `STATUS_ERR_CHECK_EN` defined): `rd_resp` at count 0 → `status_err` = 1 and the counter stays 0. Without the macro, `status_err` = 0.
- Reset mid-job: reset while in RUN with 4 reads outstanding. Expect all outputs to return to their reset values the next cycle and `job_counter` to be unchanged from before the job (the job is not counted).
